// File: rtl/aos_stream_bridge.sv
// Register-mapped bridge between the memory slave adaptor and the AOS byte-stream core:
// TX holding register with TLAST, RX FIFO with overflow policy, counters, flush and IRQ.
module aos_stream_bridge #(
    parameter int DATA_WIDTH      = 32,
    parameter int STRM_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FRAME_W_WIDTH   = 9,
    parameter int DEFAULT_FRAME   = 128,
    parameter int RX_BACKPRESSURE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_req_i,
    input  logic [1:0]               mem_addr_i,
    input  logic                     mem_we_i,
    input  logic [3:0]               mem_be_i,
    input  logic [DATA_WIDTH-1:0]    mem_wdata_i,
    output logic [DATA_WIDTH-1:0]    mem_rdata_o,
    output logic [FRAME_W_WIDTH-1:0] frame_width_o,
    output logic [STRM_WIDTH-1:0]    strm_in_data_o,
    output logic                     strm_in_last_o,
    output logic                     strm_in_valid_o,
    input  logic                     strm_in_ready_i,
    input  logic [STRM_WIDTH-1:0]    strm_out_data_i,
    input  logic                     strm_out_last_i,
    input  logic                     strm_out_valid_i,
    output logic                     strm_out_ready_o,
    output logic                     irq_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [STRM_WIDTH:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    rx_count;
    logic                rx_empty, rx_full, rx_ovf, tx_drop, irq_en;
    logic [15:0]         ovf_cnt;
    logic [STRM_WIDTH:0] head;
    logic [31:0]         rd_word;

    logic wr, rd, data_wr, stat_wr, ctrl_wr, ovfc_wr, flush;
    logic pop, push_req, push, drop;
    logic unused;

    assign unused   = ^{mem_wdata_i, mem_be_i};

    assign wr       = mem_req_i & mem_we_i;
    assign rd       = mem_req_i & ~mem_we_i;
    assign data_wr  = wr & (mem_addr_i == 2'd0) & mem_be_i[0];
    assign stat_wr  = wr & (mem_addr_i == 2'd1) & mem_be_i[3];
    assign ctrl_wr  = wr & (mem_addr_i == 2'd2);
    assign ovfc_wr  = wr & (mem_addr_i == 2'd3);
    assign flush    = ctrl_wr & mem_be_i[3] & mem_wdata_i[31];

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_W'(FIFO_DEPTH));
    assign strm_out_ready_o = (RX_BACKPRESSURE != 0) ? ~rx_full : 1'b1;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign pop      = rd & (mem_addr_i == 2'd0) & ~rx_empty;
    assign push_req = strm_out_valid_i & strm_out_ready_o & ~flush;
    assign push     = push_req & (~rx_full | pop);
    assign drop     = push_req & rx_full & ~pop;
    assign head     = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo_mem[wr_ptr] <= {strm_out_last_i, strm_out_data_i};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // TX holding register: a write while valid (including the handshake cycle) is dropped.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            strm_in_valid_o <= 1'b0;
            strm_in_data_o  <= '0;
            strm_in_last_o  <= 1'b0;
        end else if (strm_in_valid_o) begin
            if (strm_in_ready_i) strm_in_valid_o <= 1'b0;
        end else if (data_wr) begin
            strm_in_valid_o <= 1'b1;
            strm_in_data_o  <= mem_wdata_i[STRM_WIDTH-1:0];
            strm_in_last_o  <= mem_wdata_i[31];
        end
    end

    // Sticky flags: a new event in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rx_ovf  <= 1'b0;
            tx_drop <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            if (stat_wr && mem_wdata_i[28]) rx_ovf  <= 1'b0;
            if (stat_wr && mem_wdata_i[27]) tx_drop <= 1'b0;
            if (drop) rx_ovf <= 1'b1;
            if (data_wr && strm_in_valid_o) tx_drop <= 1'b1;
            if (ovfc_wr)
                ovf_cnt <= '0;
            else if (drop && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_width_o <= FRAME_W_WIDTH'(DEFAULT_FRAME);
            irq_en        <= 1'b0;
        end else if (ctrl_wr) begin
            for (int i = 0; i < FRAME_W_WIDTH; i++)
                if (mem_be_i[i/8]) frame_width_o[i] <= mem_wdata_i[i];
            if (mem_be_i[2]) irq_en <= mem_wdata_i[16];
        end
    end

    always_comb begin
        rd_word = '0;
        case (mem_addr_i)
            2'd0: if (!rx_empty) begin
                rd_word[31]             = 1'b1;
                rd_word[30]             = head[STRM_WIDTH];
                rd_word[STRM_WIDTH-1:0] = head[STRM_WIDTH-1:0];
            end
            2'd1: rd_word = {strm_in_valid_o, rx_empty, rx_full, rx_ovf, tx_drop,
                             11'b0, 16'(rx_count)};
            2'd2: begin
                rd_word[FRAME_W_WIDTH-1:0] = frame_width_o;
                rd_word[16]                = irq_en;
            end
            default: rd_word[15:0] = ovf_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata_o <= '0;
            irq_o       <= 1'b0;
        end else begin
            mem_rdata_o <= '0;
            if (rd) mem_rdata_o[31:0] <= rd_word;
            irq_o <= irq_en & (~rx_empty | rx_ovf | tx_drop);
        end
    end
endmodule

// File: tb/tb_aos_stream_bridge.sv
// Scoreboard bench for aos_stream_bridge: one drop-on-full instance and one backpressure instance.
module tb_aos_stream_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic [8:0]  fw0, fw1;
    logic [7:0]  tx_data0, tx_data1;
    logic        tx_last0, tx_last1, tx_valid0, tx_valid1, tx_ready0;
    logic [7:0]  rx_data;
    logic        rx_last, rx_valid0, rx_valid1, rx_ready0, rx_ready1;
    logic        irq0, irq1;

    int n_chk = 0;
    int n_err = 0;
    logic [8:0] sb0[$];
    logic [8:0] sb1[$];

    always #5 clk = ~clk;

    aos_stream_bridge #(.RX_BACKPRESSURE(0)) dut0 (
        .clk(clk), .rst(rst), .mem_req_i(req0), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rdata_o(rdata0), .frame_width_o(fw0),
        .strm_in_data_o(tx_data0), .strm_in_last_o(tx_last0), .strm_in_valid_o(tx_valid0),
        .strm_in_ready_i(tx_ready0), .strm_out_data_i(rx_data), .strm_out_last_i(rx_last),
        .strm_out_valid_i(rx_valid0), .strm_out_ready_o(rx_ready0), .irq_o(irq0));

    aos_stream_bridge #(.RX_BACKPRESSURE(1)) dut1 (
        .clk(clk), .rst(rst), .mem_req_i(req1), .mem_addr_i(addr), .mem_we_i(we),
        .mem_be_i(be), .mem_wdata_i(wdata), .mem_rdata_o(rdata1), .frame_width_o(fw1),
        .strm_in_data_o(tx_data1), .strm_in_last_o(tx_last1), .strm_in_valid_o(tx_valid1),
        .strm_in_ready_i(1'b0), .strm_out_data_i(rx_data), .strm_out_last_i(rx_last),
        .strm_out_valid_i(rx_valid1), .strm_out_ready_o(rx_ready1), .irq_o(irq1));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Bus tasks are entered at a negedge and return at the next negedge.
    task automatic bus_wr(input int s, input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; be = b; wdata = d; we = 1'b1;
        req0 = (s == 0); req1 = (s == 1);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; we = 1'b0; be = '0;
    endtask

    task automatic bus_rd(input int s, input logic [1:0] a, output logic [31:0] r);
        addr = a; we = 1'b0;
        req0 = (s == 0); req1 = (s == 1);
        @(negedge clk);
        r = (s == 0) ? rdata0 : rdata1;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    function automatic logic [31:0] dword(input logic [8:0] e);
        return {1'b1, e[8], 22'b0, e[7:0]};
    endfunction

    // Pushes one byte into dut0; the model accepts it only while the FIFO has room.
    task automatic push0(input logic [7:0] d, input logic l);
        rx_data = d; rx_last = l; rx_valid0 = 1'b1;
        if (sb0.size() < 16) sb0.push_back({l, d});
        @(negedge clk);
        rx_valid0 = 1'b0;
    endtask

    task automatic rd_data0(input string tag);
        logic [31:0] r;
        logic [31:0] exp;
        exp = (sb0.size() > 0) ? dword(sb0.pop_front()) : 32'h0;
        bus_rd(0, 2'd0, r);
        chk(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] exp;
        int n;
        rst = 1'b1; req0 = 0; req1 = 0; we = 0; addr = 0; be = 0; wdata = 0;
        tx_ready0 = 0; rx_data = 0; rx_last = 0; rx_valid0 = 0; rx_valid1 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_fw", 32'(fw0), 32'd128);
        chk("rst_txv", 32'(tx_valid0), 32'd0);
        chk("rst_irq", 32'(irq0), 32'd0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_rdy1", 32'(rx_ready1), 32'd1);
        bus_rd(0, 2'd1, r); chk("rst_stat", r, 32'h4000_0000);

        // TX: ready low for three cycles, a second write while busy is dropped
        bus_wr(0, 2'd0, 4'h1, 32'h8000_00A5);
        chk("tx_c1", {tx_valid0, tx_last0, tx_data0}, {2'b11, 8'hA5});
        bus_wr(0, 2'd0, 4'h1, 32'h0000_005A);
        chk("tx_c2", {tx_valid0, tx_last0, tx_data0}, {2'b11, 8'hA5});
        @(negedge clk);
        chk("tx_c3", {tx_valid0, tx_last0, tx_data0}, {2'b11, 8'hA5});
        tx_ready0 = 1'b1;
        chk("tx_c4", {tx_valid0, tx_last0, tx_data0}, {2'b11, 8'hA5});
        @(negedge clk);
        tx_ready0 = 1'b0;
        chk("tx_done", 32'(tx_valid0), 32'd0);
        bus_rd(0, 2'd1, r); chk("tx_drop_stat", r, 32'h4800_0000);
        bus_wr(0, 2'd1, 4'h8, 32'h0800_0000);
        bus_rd(0, 2'd1, r); chk("tx_drop_clr", r, 32'h4000_0000);

        // Mode 0 overflow: 18 pushes into 16 entries
        for (int i = 0; i < 18; i++) push0(8'(i), (i % 4) == 3);
        bus_rd(0, 2'd1, r); chk("ovf_stat", r, 32'h3000_0010);
        bus_rd(0, 2'd3, r); chk("ovf_cnt", r, 32'd2);
        chk("rdy0_full", 32'(rx_ready0), 32'd1);
        for (int i = 0; i < 17; i++) rd_data0($sformatf("drain_%0d", i));
        bus_wr(0, 2'd1, 4'h8, 32'h1800_0000);
        bus_wr(0, 2'd3, 4'h1, 32'h0);
        bus_rd(0, 2'd1, r); chk("clr_stat", r, 32'h4000_0000);
        bus_rd(0, 2'd3, r); chk("clr_ovfc", r, 32'd0);

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 16; i++) push0(8'h40 + 8'(i), 1'b0);
        rx_data = 8'h77; rx_last = 1'b1; rx_valid0 = 1'b1;
        exp = dword(sb0.pop_front());
        sb0.push_back({1'b1, 8'h77});
        bus_rd(0, 2'd0, r);
        rx_valid0 = 1'b0; rx_last = 1'b0;
        chk("pp_data", r, exp);
        bus_rd(0, 2'd1, r); chk("pp_stat", r, 32'h2000_0010);
        bus_rd(0, 2'd3, r); chk("pp_ovfc", r, 32'd0);
        for (int i = 0; i < 16; i++) rd_data0($sformatf("pp_drain_%0d", i));
        bus_rd(0, 2'd1, r); chk("pp_empty", r, 32'h4000_0000);

        // Mode 1 backpressure: continuous stream, host idle
        n = 0;
        for (int c = 0; c < 20; c++) begin
            rx_data = 8'(n); rx_valid1 = 1'b1;
            if (rx_ready1) begin sb1.push_back({1'b0, 8'(n)}); n++; end
            @(negedge clk);
        end
        chk("bp_pushes", 32'(n), 32'd16);
        chk("bp_rdy_low", 32'(rx_ready1), 32'd0);
        exp = dword(sb1.pop_front());
        bus_rd(1, 2'd0, r);
        chk("bp_rd", r, exp);
        chk("bp_rdy_up", 32'(rx_ready1), 32'd1);
        rx_valid1 = 1'b0;
        bus_rd(1, 2'd1, r); chk("bp_stat", r, 32'h0000_000F);
        bus_rd(1, 2'd3, r); chk("bp_ovfc", r, 32'd0);

        // IRQ, frame width and flush
        bus_wr(0, 2'd2, 4'hF, 32'h0001_0040);
        chk("fw_64", 32'(fw0), 32'd64);
        chk("irq_idle", 32'(irq0), 32'd0);
        push0(8'h3C, 1'b0);
        chk("irq_lat", 32'(irq0), 32'd0);
        @(negedge clk);
        chk("irq_set", 32'(irq0), 32'd1);
        rx_data = 8'h99; rx_valid0 = 1'b1;
        bus_wr(0, 2'd2, 4'h8, 32'h8000_0000);
        rx_valid0 = 1'b0;
        sb0.delete();
        @(negedge clk);
        chk("irq_flush", 32'(irq0), 32'd0);
        chk("fw_kept", 32'(fw0), 32'd64);
        bus_rd(0, 2'd1, r); chk("flush_stat", r, 32'h4000_0000);
        bus_rd(0, 2'd2, r); chk("flush_ctrl", r, 32'h0001_0040);
        rd_data0("flush_data");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
